// File: rtl/ysyx_25040111_ifu_axil_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_25040111_ifu_axil_pkg
// Description : Shared definitions for the IFU AXI4-Lite fetch responder.
//               Provides the FSM state encoding, AXI response codes and the
//               PC reset constant shared with the IFU.
//               Define STA_SOC to select the SoC flash reset vector.
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_25040111_ifu_axil_pkg;

  // Fetch FSM states
  typedef enum logic [1:0] {
    IFU_AXIL_IDLE = 2'd0,
    IFU_AXIL_AR   = 2'd1,
    IFU_AXIL_R    = 2'd2,
    IFU_AXIL_RESP = 2'd3
  } ifu_axil_state_e;

  // AXI response codes
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // PC reset vector, shared with the IFU
`ifdef STA_SOC
  localparam logic [31:0] PC_RESET = 32'h3000_0000;
`else
  localparam logic [31:0] PC_RESET = 32'h8000_0000;
`endif

endpackage
`default_nettype wire

// File: rtl/ysyx_25040111_ifu_axil.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_25040111_ifu_axil
// Description : Fetch-side responder for the IFU instruction request port.
//               Runs one AXI4-Lite read (AR then R) per IFU request and
//               returns the instruction with a one-cycle o_ifu_ready strobe.
//               Responses the IFU no longer wants (redirect or flush) are
//               dropped; the IFU re-requests from IDLE if still interested.
// Config      : YSYX_25040111_IFU_FAULT_EN - adds o_fetch_fault /
//               o_fetch_fault_addr; a non-OKAY rresp raises a fault pulse
//               instead of delivering data. Undefined: rresp is ignored.
// Ports       : clock, reset           - clock, synchronous active-high reset
//               i_ifu_valid/i_ifu_addr - IFU fetch request
//               o_ifu_ready/o_ifu_inst - response strobe and instruction
//               i_flush                - kills the outstanding request
//               o_araddr/o_arvalid/i_arready          - AXI4-Lite AR channel
//               i_rdata/i_rresp/i_rvalid/o_rready     - AXI4-Lite R channel
//               o_fetch_fault/o_fetch_fault_addr      - fault report (opt.)
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_25040111_ifu_axil
  import ysyx_25040111_ifu_axil_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_ifu_valid,
  input  logic [ADDR_W-1:0] i_ifu_addr,
  output logic              o_ifu_ready,
  output logic [DATA_W-1:0] o_ifu_inst,
  input  logic              i_flush,
  output logic [ADDR_W-1:0] o_araddr,
  output logic              o_arvalid,
  input  logic              i_arready,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [1:0]        i_rresp,
  input  logic              i_rvalid,
  output logic              o_rready
`ifdef YSYX_25040111_IFU_FAULT_EN
  ,
  output logic              o_fetch_fault,
  output logic [ADDR_W-1:0] o_fetch_fault_addr
`endif
);

  ifu_axil_state_e   r_state;
  ifu_axil_state_e   w_next_state;
  logic [ADDR_W-1:0] r_req_addr;
  logic              r_stale;
  logic [DATA_W-1:0] r_inst;
  logic              w_accept;
  logic              w_wanted;
  logic              w_resp_ok;

  // A new request is only taken when no flush is redirecting the IFU.
  assign w_accept = i_ifu_valid & ~i_flush;

  // The IFU still wants this exact response; an address change counts as
  // stale, and a flush in RESP gates delivery combinationally.
  assign w_wanted = ~r_stale & ~i_flush & i_ifu_valid & (i_ifu_addr == r_req_addr);

`ifdef YSYX_25040111_IFU_FAULT_EN
  logic [1:0] r_resp;
  assign w_resp_ok          = (r_resp == AXI_RESP_OKAY);
  assign o_fetch_fault      = (r_state == IFU_AXIL_RESP) & w_wanted & ~w_resp_ok;
  assign o_fetch_fault_addr = r_req_addr;
`else
  // Without the fault feature the response code carries no meaning here.
  logic w_unused_rresp;
  assign w_unused_rresp = ^i_rresp;
  assign w_resp_ok      = 1'b1;
`endif

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IFU_AXIL_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    w_next_state = r_state;
    o_arvalid    = 1'b0;
    o_rready     = 1'b0;
    o_ifu_ready  = 1'b0;
    case (r_state)
      IFU_AXIL_IDLE: begin
        if (w_accept) begin
          w_next_state = IFU_AXIL_AR;
        end
      end
      IFU_AXIL_AR: begin
        // Once issued, AR stays up until accepted regardless of the IFU.
        o_arvalid = 1'b1;
        if (i_arready) begin
          w_next_state = IFU_AXIL_R;
        end
      end
      IFU_AXIL_R: begin
        o_rready = 1'b1;
        if (i_rvalid) begin
          w_next_state = IFU_AXIL_RESP;
        end
      end
      IFU_AXIL_RESP: begin
        o_ifu_ready  = w_wanted & w_resp_ok;
        w_next_state = IFU_AXIL_IDLE;
      end
      default: begin
        w_next_state = IFU_AXIL_IDLE;
      end
    endcase
  end

  // Request / response datapath
  always_ff @(posedge clock) begin
    if (reset) begin
      r_req_addr <= '0;
      r_stale    <= 1'b0;
      r_inst     <= '0;
`ifdef YSYX_25040111_IFU_FAULT_EN
      r_resp     <= AXI_RESP_OKAY;
`endif
    end else begin
      case (r_state)
        IFU_AXIL_IDLE: begin
          if (w_accept) begin
            r_req_addr <= i_ifu_addr;
            r_stale    <= 1'b0;
          end
        end
        IFU_AXIL_AR: begin
          if (i_flush) begin
            r_stale <= 1'b1;
          end
        end
        IFU_AXIL_R: begin
          if (i_flush) begin
            r_stale <= 1'b1;
          end
          if (i_rvalid) begin
            r_inst <= i_rdata;
`ifdef YSYX_25040111_IFU_FAULT_EN
            r_resp <= i_rresp;
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_araddr   = r_req_addr;
  assign o_ifu_inst = r_inst;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25040111_ifu_axil.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_25040111_ifu_axil
// Description : Self-checking bench for ysyx_25040111_ifu_axil. A behavioural
//               AXI4-Lite slave with configurable AR/R wait states returns a
//               word derived from the address; each fetch is judged against
//               transaction-level expectations (latency 3 + waits, data,
//               AR count, response count).
// Config      : YSYX_25040111_IFU_FAULT_EN selects fault-port expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_25040111_ifu_axil;

  logic        clock = 1'b0;
  logic        reset;
  logic        i_ifu_valid;
  logic [31:0] i_ifu_addr;
  logic        o_ifu_ready;
  logic [31:0] o_ifu_inst;
  logic        i_flush;
  logic [31:0] o_araddr;
  logic        o_arvalid;
  logic        i_arready;
  logic [31:0] i_rdata;
  logic [1:0]  i_rresp;
  logic        i_rvalid;
  logic        o_rready;
`ifdef YSYX_25040111_IFU_FAULT_EN
  logic        o_fetch_fault;
  logic [31:0] o_fetch_fault_addr;
`endif

  always #5 clock = ~clock;

  ysyx_25040111_ifu_axil #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .i_ifu_valid (i_ifu_valid),
    .i_ifu_addr  (i_ifu_addr),
    .o_ifu_ready (o_ifu_ready),
    .o_ifu_inst  (o_ifu_inst),
    .i_flush     (i_flush),
    .o_araddr    (o_araddr),
    .o_arvalid   (o_arvalid),
    .i_arready   (i_arready),
    .i_rdata     (i_rdata),
    .i_rresp     (i_rresp),
    .i_rvalid    (i_rvalid),
    .o_rready    (o_rready)
`ifdef YSYX_25040111_IFU_FAULT_EN
    ,
    .o_fetch_fault      (o_fetch_fault),
    .o_fetch_fault_addr (o_fetch_fault_addr)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Slave configuration and bookkeeping
  int          ard, rd;
  logic [1:0]  rresp_cfg;
  int          ar_wait, r_wait;
  logic        has_pend;
  logic [31:0] pend_addr;
  int          cyc, rdy_cyc, n_ar, n_rdy, n_fault, unstable;
  logic [31:0] last_inst, last_ar_addr, c1_araddr, last_fault_addr;
  logic        prev_ar_wait;
  logic [31:0] prev_araddr;

  // Memory contents seen by the slave
  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0000_0413;
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    n_ar = 0; n_rdy = 0; n_fault = 0; cyc = 0; rdy_cyc = -1;
    unstable = 0; ar_wait = 0; r_wait = 0; prev_ar_wait = 1'b0;
  endtask

  // One clock cycle: slave reacts, outputs are sampled, then the edge.
  task automatic tick();
    i_arready = 1'b0;
    i_rvalid  = 1'b0;
    i_rresp   = 2'b00;
    if (o_arvalid) begin
      if (ar_wait >= ard) begin i_arready = 1'b1; ar_wait = 0; end
      else ar_wait++;
    end
    if (o_rready && has_pend) begin
      if (r_wait >= rd) begin
        i_rvalid = 1'b1; i_rdata = mem(pend_addr); i_rresp = rresp_cfg; r_wait = 0;
      end else r_wait++;
    end
    #1;
    if (cyc == 1) c1_araddr = o_araddr;
    if (o_arvalid && prev_ar_wait && (o_araddr !== prev_araddr)) unstable++;
    prev_ar_wait = o_arvalid && !i_arready;
    prev_araddr  = o_araddr;
    if (o_ifu_ready) begin n_rdy++; last_inst = o_ifu_inst; rdy_cyc = cyc; end
`ifdef YSYX_25040111_IFU_FAULT_EN
    if (o_fetch_fault) begin n_fault++; last_fault_addr = o_fetch_fault_addr; end
`endif
    if (o_arvalid && i_arready) begin
      n_ar++; last_ar_addr = o_araddr; pend_addr = o_araddr; has_pend = 1'b1;
    end
    if (o_rready && i_rvalid) has_pend = 1'b0;
    @(posedge clock); #1;
    cyc++;
  endtask

  task automatic run_until_done(input int budget);
    while (n_rdy == 0 && n_fault == 0 && cyc < budget) tick();
    chk("response_seen", 32'((n_rdy + n_fault) != 0), 32'd1);
  endtask

  initial begin
    logic [31:0] a;
    reset = 1'b1; i_ifu_valid = 1'b0; i_ifu_addr = '0; i_flush = 1'b0;
    i_arready = 1'b0; i_rdata = '0; i_rresp = '0; i_rvalid = 1'b0;
    ard = 0; rd = 0; rresp_cfg = 2'b00; has_pend = 1'b0; pend_addr = '0;
    last_inst = '0; last_ar_addr = '0; c1_araddr = '0; last_fault_addr = '0;
    prev_araddr = '0;
    clr();
    @(posedge clock); #1;
    tick(); tick();
    reset = 1'b0;
    chk("rst_arvalid", 32'(o_arvalid), 32'd0);
    chk("rst_rready", 32'(o_rready), 32'd0);
    chk("rst_ifu_ready", 32'(o_ifu_ready), 32'd0);
    chk("rst_ifu_inst", o_ifu_inst, 32'd0);
    chk("rst_araddr", o_araddr, 32'd0);
`ifdef YSYX_25040111_IFU_FAULT_EN
    chk("rst_fault", 32'(o_fetch_fault), 32'd0);
    chk("rst_fault_addr", o_fetch_fault_addr, 32'd0);
`endif

    // Basic zero-wait fetch
    clr(); ard = 0; rd = 0;
    i_ifu_valid = 1'b1; i_ifu_addr = 32'h8000_0000;
    run_until_done(20);
    i_ifu_valid = 1'b0;
    tick(); tick();
    chk("basic_c1_araddr", c1_araddr, 32'h8000_0000);
    chk("basic_latency", 32'(rdy_cyc), 32'd3);
    chk("basic_inst", last_inst, 32'h0000_0413);
    chk("basic_n_ar", 32'(n_ar), 32'd1);
    chk("basic_n_rdy", 32'(n_rdy), 32'd1);

    // AR wait 2, R wait 3
    clr(); ard = 2; rd = 3;
    i_ifu_valid = 1'b1; i_ifu_addr = 32'h8000_0040;
    run_until_done(30);
    i_ifu_valid = 1'b0;
    tick(); tick(); tick();
    chk("wait_latency", 32'(rdy_cyc), 32'd8);
    chk("wait_ar_stable", 32'(unstable), 32'd0);
    chk("wait_n_rdy", 32'(n_rdy), 32'd1);
    chk("wait_n_ar", 32'(n_ar), 32'd1);
    chk("wait_inst", last_inst, mem(32'h8000_0040));

    // Redirect while in R
    clr(); ard = 0; rd = 3;
    i_ifu_valid = 1'b1; i_ifu_addr = 32'h8000_0004;
    while (!o_rready && cyc < 20) tick();
    chk("redir_in_r", 32'(o_rready), 32'd1);
    i_ifu_addr = 32'h8000_0100;
    run_until_done(40);
    i_ifu_valid = 1'b0;
    tick(); tick();
    chk("redir_n_ar", 32'(n_ar), 32'd2);
    chk("redir_ar_addr", last_ar_addr, 32'h8000_0100);
    chk("redir_n_rdy", 32'(n_rdy), 32'd1);
    chk("redir_inst", last_inst, mem(32'h8000_0100));

    // Flush pulse while AR waits: first response dropped, re-fetch delivered
    clr(); ard = 3; rd = 0;
    i_ifu_valid = 1'b1; i_ifu_addr = 32'h8000_0010;
    tick();
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    run_until_done(40);
    i_ifu_valid = 1'b0;
    tick(); tick();
    chk("flush_latency", 32'(rdy_cyc), 32'd13);
    chk("flush_n_ar", 32'(n_ar), 32'd2);
    chk("flush_n_rdy", 32'(n_rdy), 32'd1);
    chk("flush_inst", last_inst, mem(32'h8000_0010));
    chk("flush_idle_arvalid", 32'(o_arvalid), 32'd0);
    chk("flush_idle_rready", 32'(o_rready), 32'd0);

    // Error response
    clr(); ard = 0; rd = 0; rresp_cfg = 2'b10;
    i_ifu_valid = 1'b1; i_ifu_addr = 32'h8000_0008;
    run_until_done(20);
    i_ifu_valid = 1'b0;
    rresp_cfg = 2'b00;
    tick(); tick();
`ifdef YSYX_25040111_IFU_FAULT_EN
    chk("fault_n_rdy", 32'(n_rdy), 32'd0);
    chk("fault_n_fault", 32'(n_fault), 32'd1);
    chk("fault_addr", last_fault_addr, 32'h8000_0008);
`else
    chk("noflt_n_rdy", 32'(n_rdy), 32'd1);
    chk("noflt_latency", 32'(rdy_cyc), 32'd3);
    chk("noflt_inst", last_inst, mem(32'h8000_0008));
`endif

    // Reset while in R
    clr(); ard = 0; rd = 5;
    i_ifu_valid = 1'b1; i_ifu_addr = 32'h8000_0020;
    tick(); tick();
    chk("rst_mid_in_r", 32'(o_rready), 32'd1);
    i_ifu_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid_arvalid", 32'(o_arvalid), 32'd0);
    chk("rst_mid_rready", 32'(o_rready), 32'd0);
    chk("rst_mid_ifu_ready", 32'(o_ifu_ready), 32'd0);
    has_pend = 1'b0;
    clr(); rd = 0;
    i_ifu_valid = 1'b1; i_ifu_addr = 32'h8000_0024;
    run_until_done(20);
    chk("rst_mid_latency", 32'(rdy_cyc), 32'd3);
    chk("rst_mid_inst", last_inst, mem(32'h8000_0024));
    chk("rst_mid_n_ar", 32'(n_ar), 32'd1);

    // Randomized back-to-back fetches with random wait states
    for (int i = 0; i < 24; i++) begin
      clr();
      a   = $urandom;
      a   = {a[31:2], 2'b00};
      ard = $urandom_range(0, 3);
      rd  = $urandom_range(0, 3);
      i_ifu_valid = 1'b1; i_ifu_addr = a;
      run_until_done(40);
      chk("rand_latency", 32'(rdy_cyc), 32'(3 + ard + rd));
      chk("rand_inst", last_inst, mem(a));
      chk("rand_n_ar", 32'(n_ar), 32'd1);
    end
    i_ifu_valid = 1'b0;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ysyx_25040111_ifu_axil.md
# ysyx_25040111_ifu_axil

Fetch-side responder for the IFU instruction request port: accepts the IFU's `ifu_valid`/`ifu_addr` request, runs one AXI4-Lite read (AR/R) per request, and returns the 32-bit instruction with a one-cycle `ifu_ready` pulse. It sits between the IFU and the instruction-side AXI4-Lite interconnect (SRAM/flash/xbar). It discards responses that the IFU no longer wants because of a jump redirect or an error flush.

## Interface
- `ADDR_W`, default 32: fetch address width.
- `DATA_W`, default 32: instruction width; fixed at 32, no other value is supported.
- `clock`  in  1  system clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high.
- `ifu_valid`  in  1  IFU fetch request; may drop or change address at any cycle.
- `ifu_addr`  in  32  fetch PC.
- `ifu_ready`  out  1  one-cycle response strobe; `ifu_inst` is valid in the same cycle.
- `ifu_inst`  out  32  fetched instruction.
- `flush`  in  1  error/trap redirect; kills the outstanding request.
- `araddr`  out  32, `arvalid`  out  1, `arready`  in  1: AXI4-Lite AR channel.
- `rdata`  in  32, `rresp`  in  2, `rvalid`  in  1, `rready`  out  1: AXI4-Lite R channel.
- `fetch_fault`  out  1, `fetch_fault_addr`  out  32: present only with `YSYX_25040111_IFU_FAULT_EN`.

## Operation
- FSM states: IDLE, AR, R, RESP.
- **IDLE**
  - If `ifu_valid & ~flush`: latch `req_addr <= ifu_addr`, clear `stale`, go to AR.
  - Otherwise, stay in IDLE.
- **AR**
  - `arvalid = 1`; `araddr = req_addr`, held stable.
  - On `arready`, go to R.
  - AR is never retracted once issued (AXI rule), even if `ifu_valid` drops.
- **R**
  - `rready = 1`.
  - On `rvalid`: latch `inst_q <= rdata` and `resp_q <= rresp`, then go to RESP.
- **RESP**
  - Deliver only if `~stale & ~flush & ifu_valid & (ifu_addr == req_addr)`, plus `resp_q == OKAY` when the fault feature is enabled.
  - When delivering, `ifu_ready = 1` and `ifu_inst = inst_q`.
  - Always return to IDLE the next cycle. If the IFU still wants a fetch, IDLE re-issues it.
- **Stale marking:** `flush` in AR or R sets `stale`. An address mismatch in RESP is treated as stale.
- **Outputs:** `ifu_inst` holds `inst_q` at all times; it is only meaningful while `ifu_ready` is high.
- **Reset values:** state = IDLE; `arvalid`, `rready`, `ifu_ready`, `fetch_fault` = 0; `ifu_inst`, `araddr`, `fetch_fault_addr` = 0.
- **Ordering:** one outstanding transaction at most; no reordering, no prefetch.

## Timing
- Minimum latency from `ifu_valid` sampled in IDLE to `ifu_ready` is 3 cycles (zero-wait slave):
  - c0: IDLE latches the request.
  - c1: AR with `arready`.
  - c2: R with `rvalid`.
  - c3: RESP, `ifu_ready`.
- Each AR wait cycle and each R wait cycle adds one cycle.
- Back-to-back fetches: the earliest next request is sampled the cycle after RESP, giving 4-cycle throughput.
- **Flush:**
  - Flush in IDLE blocks latching that cycle.
  - Flush in RESP suppresses `ifu_ready` in the same cycle (combinational gate).
- **Reset mid-transaction:** the FSM returns to IDLE immediately. The slave shares `reset`, so no response is drained.

## Configuration
- `YSYX_25040111_IFU_FAULT_EN`, when defined:
  - `rresp != 2'b00` in RESP suppresses `ifu_ready`.
  - Instead it pulses `fetch_fault` for one cycle with `fetch_fault_addr = req_addr`, but only if the request is not stale.
  - The trap unit uses this pulse to drive the IFU `err`/`errpc`.
- When undefined: `rresp` is ignored and data is always delivered; the fault ports and `resp_q` do not exist.

## Structure
- Shared package/header holds:
  - State encodings (`IFU_AXIL_IDLE/AR/R/RESP`).
  - AXI resp constants (`AXI_RESP_OKAY = 2'b00`, `SLVERR`, `DECERR`).
  - The PC reset constants (`30000000` under `STA_SOC`, else `80000000`), shared with the IFU.
- Single flat module, no sub-module. The FSM and datapath registers are small enough that a split would only add ports.

## Test plan
- **Basic fetch:** reset, `ifu_valid=1`, `ifu_addr=0x80000000`, slave zero-wait with `rdata=0x00000413` → `araddr=0x80000000` on c1, `ifu_ready=1` with `ifu_inst=0x00000413` on c3, exactly one AR.
- **Wait states:** slave inserts `arready` delay 2 and `rvalid` delay 3 → `arvalid` and `araddr` stable throughout, `ifu_ready` on c8, single pulse.
- **Redirect during R:** while in R, the IFU changes `ifu_addr` from `0x80000004` to `0x80000100` → stale response dropped (no `ifu_ready`), new AR to `0x80000100`, and its data delivered.
- **Flush in AR:** `flush` pulse while `arvalid` waits → AR still completes and R is accepted, no `ifu_ready`; returns to IDLE.
- **Fault (macro defined):** `rresp=2'b10` at `0x80000008` → `fetch_fault=1` for one cycle, `fetch_fault_addr=0x80000008`, `ifu_ready=0`. With the macro undefined, same stimulus → `ifu_ready=1` with `rdata`.
- **Reset mid-transaction:** assert `reset` in R → next cycle state IDLE with `arvalid=0`, `rready=0`, `ifu_ready=0`; a subsequent fetch works normally.
